input_control_unit: RTL and testbench
=====================================

Name: input_control_unit

Overview:
Streaming input stager for the Winograd F(2,3) convolution datapath. Accepts a channel-interleaved pixel stream row by row and writes it into six rotating row line buffers. Four buffers are read out as n x n (4x4) tiles across all M channels at a column stride of 2. The other two buffers fill with the next two rows at the same time.

Parameters:
M, 3, number of channels (interleaved per pixel)
W, 512, image width in pixels; one row = M*W bytes
n, 4, tile size (rows and columns); design fixed at 4, tile stride 2

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; synchronous, active-high; clock i_clk
i_pixel_data  in  8  pixel byte; stream order row, x, channel
i_pixel_data_valid  in  1  pixel qualifier; no back-pressure
proc_finish  in  1  downstream consumed the current tile (1-cycle pulse)
o_input_tile_across_all_channel  out  M*n*n*8 (384)  byte [(c*16+r*4+k)*8 +: 8] = channel c, tile row r (0 = oldest row), column k
o_ready  out  1  tile output valid

Behaviour:
- Reset:
  - current_state = INIT_STATE (2'd0).
  - fill_counter = 0, read_counter = 0 (20 bits each).
  - All six wrPntr = 0.
  - o_ready = 0; tile output = 0.
  - Buffer contents are not reset.
- Line buffer byte index = x*M + c. wrPntr (11 b) increments per written byte and wraps M*W-1 -> 0.
- Routing:
  - pixel_to_lbK carries i_pixel_data to buffer K.
  - valid_to_lbK is high only for the current fill target, and only when i_pixel_data_valid is high and the fill is not complete.
  - In a fill phase, the first M*W bytes go to target A and the next M*W go to target B.
- States, as (fill targets / read rows oldest->newest):
  - INIT_STATE (0): fill LB1..LB4 sequentially, 4*M*W bytes; no reads.
  - STATE1 (1): fill LB5, LB6 / read LB1, LB2, LB3, LB4.
  - STATE2 (2): fill LB1, LB2 / read LB3, LB4, LB5, LB6.
  - STATE3 (3): fill LB3, LB4 / read LB5, LB6, LB1, LB2.
- Transitions:
  - INIT -> STATE1 on the cycle the 4*M*W-th byte is written.
  - STATE1 -> STATE2 -> STATE3 -> STATE1 when both conditions hold: the fill is complete (2*M*W bytes) and the last tile has been consumed.
  - If both conditions occur in the same cycle, transition that cycle.
  - fill_counter and read_counter clear on every transition.
- Fill complete but reads pending: incoming valid bytes are discarded. The system must rate-match the stream.
- Reads:
  - Tiles per row group T = (W-n)/2+1 = 255.
  - Tile t uses columns 2t..2t+3.
  - The tile register loads one cycle after entering a read state, and one cycle after each accepted proc_finish; o_ready = 1 from that cycle on.
  - proc_finish while o_ready = 1: o_ready drops next cycle and read_counter increments.
  - On the last tile (read_counter = T-1), proc_finish ends reads for the state.
  - proc_finish with o_ready = 0 is ignored.
- Reset mid-operation: returns to INIT; the partial image is discarded.
- There are no frame/height boundaries; the stream is treated as continuous rows.

Optional Feature:
ICU_AUTO_ADVANCE_EN
- Defined: proc_finish is ignored. Each o_ready cycle counts as consumed, so one tile is produced every 2 cycles.
- Undefined: tiles advance only on proc_finish, as above.

Decomposition:
- Shared package icu_pkg:
  - state encodings INIT_STATE / STATE1 / STATE2 / STATE3;
  - tile count T;
  - byte-index helper x*M+c.
- One sub-module icu_line_buffer, instantiated as LB1..LB6 (names fixed for bench hierarchical access):
  - storage array `line[0:M*W-1]`;
  - 11-bit wrPntr;
  - combinational read of n*M bytes at a given base column.
- Internal signal names fixed for the bench: current_state, fill_counter, read_counter, pixel_to_lbK, valid_to_lbK.

Test Plan:
- Reset, then stream bytes (count mod 256), valid held high:
  - all wrPntr = 0 during reset;
  - only valid_to_lb1 is high for the first 1536 bytes;
  - LB1.wrPntr wraps to 0 at byte 1536.
- After 6144 bytes:
  - current_state = 1;
  - LB1[0] = 0, LB1[1535] = 255, LB4[3] = 3;
  - one cycle later o_ready = 1.
- First tile:
  - channel 0 row 0 = 0, 3, 6, 9;
  - channel 1 row 0 = 1, 4, 7, 10;
  - channel 2 row 3 = 2, 5, 8, 11.
- Pulse proc_finish:
  - o_ready low for 1 cycle;
  - next tile channel 0 row 0 = 6, 9, 12, 15;
  - read_counter = 1.
- Hold proc_finish off while 3072 more bytes arrive:
  - further bytes are discarded (wrPntr LB5/LB6 stable);
  - state stays 1 until tile 254 is consumed, then state = 2.
- Assert i_rst mid-STATE2:
  - next cycle state = 0, o_ready = 0, counters and wrPntr = 0.

Source files
------------

// File: rtl/icu_pkg.sv
// icu_pkg: shared constants, state encoding and indexing helpers for input_control_unit
// Contents: ICU_M/ICU_W/ICU_N defaults, state_t (INIT_STATE/STATE1/STATE2/STATE3),
// tile_count(w,n) tiles per row group, ICU_T default tile count,
// byte_idx(x,c,m) line buffer byte index x*m+c.
package icu_pkg;
  localparam int ICU_M = 3;
  localparam int ICU_W = 512;
  localparam int ICU_N = 4;
  typedef enum logic [1:0] {
    INIT_STATE = 2'd0,
    STATE1     = 2'd1,
    STATE2     = 2'd2,
    STATE3     = 2'd3
  } state_t;
  function automatic int tile_count(input int w, input int n);
    return (w - n) / 2 + 1;
  endfunction
  localparam int ICU_T = tile_count(ICU_W, ICU_N);
  function automatic logic [10:0] byte_idx(input int x, input int c, input int m);
    return 11'(x * m + c);
  endfunction
endpackage

// File: rtl/icu_line_buffer.sv
// icu_line_buffer: one image row of M-channel interleaved bytes with a windowed read
// Ports: i_clk, i_rst (sync, active-high, clears wrPntr only),
// i_data/i_valid write one byte at wrPntr (wraps at M*W-1),
// i_base_col first pixel column of the window,
// o_data N columns x M channels, byte (k*M+c) = column base+k, channel c.
module icu_line_buffer
  import icu_pkg::*;
#(
  parameter int M = ICU_M,
  parameter int W = ICU_W,
  parameter int N = ICU_N
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  input  logic [9:0]       i_base_col,
  output logic [N*M*8-1:0] o_data
);
  logic [7:0] line [0:M*W-1];
  logic [10:0] wrPntr, wr_pntr_d;
  always_comb wr_pntr_d = !i_valid ? wrPntr : wrPntr == 11'(M*W-1) ? '0 : wrPntr + 11'd1;
  always_ff @(posedge i_clk) wrPntr <= i_rst ? '0 : wr_pntr_d;
  always_ff @(posedge i_clk) if (i_valid && !i_rst) line[wrPntr] <= i_data;
  for (genvar k = 0; k < N; k++) begin : g_col
    for (genvar c = 0; c < M; c++) begin : g_ch
      assign o_data[(k*M+c)*8 +: 8] = line[byte_idx(int'(i_base_col) + k, c, M)];
    end
  end
endmodule

// File: rtl/input_control_unit.sv
// input_control_unit: stages a channel-interleaved pixel stream into six rotating line buffers and emits 4x4xM tiles
// Ports: i_clk, i_rst (sync, active-high), i_pixel_data/i_pixel_data_valid (stream, no back-pressure),
// proc_finish (tile consumed pulse), o_input_tile_across_all_channel (byte (c*16+r*4+k), r=0 oldest row),
// o_ready (tile valid).
// Build option ICU_AUTO_ADVANCE_EN: ignore proc_finish and treat every o_ready cycle as consumed.
module input_control_unit
  import icu_pkg::*;
#(
  parameter int M = ICU_M,
  parameter int W = ICU_W,
  parameter int N = ICU_N
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_pixel_data,
  input  logic               i_pixel_data_valid,
  input  logic               proc_finish,
  output logic [M*N*N*8-1:0] o_input_tile_across_all_channel,
  output logic               o_ready
);
  localparam int RB = M * W;
  localparam int TILES = tile_count(W, N);
  state_t current_state, next_state;
  logic [19:0] fill_counter, fill_counter_d, read_counter, read_counter_d, fill_len;
  logic read_done_q, read_done_d, load_q, load_d, ready_q, ready_d;
  logic [M*N*N*8-1:0] tile_q, tile_d, tile_rd;
  logic [M*N*8-1:0] lb_out [0:5];
  logic [9:0] base_col;
  logic [2:0] fill_base, read_base, fill_tgt;
  logic fill_done, write_en, accept, last_tile, fill_fin, read_fin, advance;
  logic [7:0] pixel_to_lb1, pixel_to_lb2, pixel_to_lb3, pixel_to_lb4, pixel_to_lb5, pixel_to_lb6;
  logic valid_to_lb1, valid_to_lb2, valid_to_lb3, valid_to_lb4, valid_to_lb5, valid_to_lb6;
`ifdef ICU_AUTO_ADVANCE_EN
  assign accept = ready_q;
`else
  assign accept = ready_q && proc_finish;
`endif
  always_comb begin
    fill_len = current_state == INIT_STATE ? 20'(4*RB) : 20'(2*RB);
    read_base = current_state == STATE2 ? 3'd2 : current_state == STATE3 ? 3'd4 : 3'd0;
    fill_base = current_state == STATE1 ? 3'd4 : current_state == STATE3 ? 3'd2 : 3'd0;
    fill_tgt = fill_base + (fill_counter >= 20'(3*RB) ? 3'd3 : fill_counter >= 20'(2*RB) ? 3'd2 :
                            fill_counter >= 20'(RB) ? 3'd1 : 3'd0);
    fill_done = fill_counter == fill_len;
    write_en = i_pixel_data_valid && !fill_done;
    last_tile = read_counter == 20'(TILES-1);
    // A state ends once its fill is complete and its last tile is consumed; either may land this cycle.
    fill_fin = fill_done || (write_en && fill_counter == fill_len - 20'd1);
    read_fin = current_state == INIT_STATE || read_done_q || (accept && last_tile);
    advance = fill_fin && read_fin;
    next_state = !advance ? current_state : current_state == STATE3 ? STATE1 : state_t'(current_state + 2'd1);
    fill_counter_d = advance ? '0 : fill_counter + 20'(write_en);
    read_counter_d = advance ? '0 : read_counter + 20'(accept && !last_tile);
    read_done_d = !advance && (read_done_q || (accept && last_tile));
    load_d = advance || (accept && !last_tile);
    ready_d = !advance && (load_q || (ready_q && !accept));
    base_col = 10'(read_counter << 1);
    tile_rd = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        for (int k = 0; k < N; k++)
          tile_rd[(c*N*N + r*N + k)*8 +: 8] = lb_out[3'((int'(read_base) + r) % 6)][(k*M + c)*8 +: 8];
    tile_d = load_q ? tile_rd : tile_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      current_state <= INIT_STATE;
      fill_counter <= '0;
      read_counter <= '0;
      read_done_q <= 1'b0;
      load_q <= 1'b0;
      ready_q <= 1'b0;
      tile_q <= '0;
    end else begin
      current_state <= next_state;
      fill_counter <= fill_counter_d;
      read_counter <= read_counter_d;
      read_done_q <= read_done_d;
      load_q <= load_d;
      ready_q <= ready_d;
      tile_q <= tile_d;
    end
  end
  assign pixel_to_lb1 = i_pixel_data;
  assign pixel_to_lb2 = i_pixel_data;
  assign pixel_to_lb3 = i_pixel_data;
  assign pixel_to_lb4 = i_pixel_data;
  assign pixel_to_lb5 = i_pixel_data;
  assign pixel_to_lb6 = i_pixel_data;
  assign valid_to_lb1 = write_en && fill_tgt == 3'd0;
  assign valid_to_lb2 = write_en && fill_tgt == 3'd1;
  assign valid_to_lb3 = write_en && fill_tgt == 3'd2;
  assign valid_to_lb4 = write_en && fill_tgt == 3'd3;
  assign valid_to_lb5 = write_en && fill_tgt == 3'd4;
  assign valid_to_lb6 = write_en && fill_tgt == 3'd5;
  icu_line_buffer #(.M(M), .W(W), .N(N)) LB1 (.i_clk(i_clk), .i_rst(i_rst), .i_data(pixel_to_lb1),
    .i_valid(valid_to_lb1), .i_base_col(base_col), .o_data(lb_out[0]));
  icu_line_buffer #(.M(M), .W(W), .N(N)) LB2 (.i_clk(i_clk), .i_rst(i_rst), .i_data(pixel_to_lb2),
    .i_valid(valid_to_lb2), .i_base_col(base_col), .o_data(lb_out[1]));
  icu_line_buffer #(.M(M), .W(W), .N(N)) LB3 (.i_clk(i_clk), .i_rst(i_rst), .i_data(pixel_to_lb3),
    .i_valid(valid_to_lb3), .i_base_col(base_col), .o_data(lb_out[2]));
  icu_line_buffer #(.M(M), .W(W), .N(N)) LB4 (.i_clk(i_clk), .i_rst(i_rst), .i_data(pixel_to_lb4),
    .i_valid(valid_to_lb4), .i_base_col(base_col), .o_data(lb_out[3]));
  icu_line_buffer #(.M(M), .W(W), .N(N)) LB5 (.i_clk(i_clk), .i_rst(i_rst), .i_data(pixel_to_lb5),
    .i_valid(valid_to_lb5), .i_base_col(base_col), .o_data(lb_out[4]));
  icu_line_buffer #(.M(M), .W(W), .N(N)) LB6 (.i_clk(i_clk), .i_rst(i_rst), .i_data(pixel_to_lb6),
    .i_valid(valid_to_lb6), .i_base_col(base_col), .o_data(lb_out[5]));
  assign o_ready = ready_q;
  assign o_input_tile_across_all_channel = tile_q;
endmodule

// File: tb/tb_input_control_unit.sv
// tb_input_control_unit: directed self-checking bench for input_control_unit
module tb_input_control_unit;
  logic i_clk = 1'b0, i_rst = 1'b1, i_pixel_data_valid = 1'b0, proc_finish = 1'b0, o_ready;
  logic [7:0] i_pixel_data = 8'd0;
  logic [383:0] tile;
  int checks = 0, failures = 0, cnt = 0;
  always #5 i_clk = ~i_clk;
  input_control_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pixel_data(i_pixel_data), .i_pixel_data_valid(i_pixel_data_valid),
    .proc_finish(proc_finish), .o_input_tile_across_all_channel(tile), .o_ready(o_ready)
  );
  function automatic logic [31:0] row32(input logic [383:0] t, input int c, input int r);
    return {t[(c*16+r*4)*8 +: 8], t[(c*16+r*4+1)*8 +: 8], t[(c*16+r*4+2)*8 +: 8], t[(c*16+r*4+3)*8 +: 8]};
  endfunction
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic send(input int nbytes, input bit chk, input logic [5:0] exp_vec);
    logic [5:0] vv;
    for (int i = 0; i < nbytes; i++) begin
      i_pixel_data = cnt[7:0];
      i_pixel_data_valid = 1'b1;
      #1;
      if (chk) begin
        checks++;
        vv = {dut.valid_to_lb6, dut.valid_to_lb5, dut.valid_to_lb4, dut.valid_to_lb3, dut.valid_to_lb2, dut.valid_to_lb1};
        if (vv !== exp_vec) begin
          failures++;
          $display("FAIL valid_route byte=%0d got=%b want=%b", i, vv, exp_vec);
        end
      end
      tick;
      cnt++;
    end
    i_pixel_data_valid = 1'b0;
  endtask
  task automatic wait_ready;
    for (int i = 0; i < 8 && !o_ready; i++) tick;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready timeout got=%b want=1", o_ready);
    end
  endtask
  task automatic test_reset;
    i_rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({dut.current_state, dut.fill_counter, dut.read_counter} !== 42'd0) begin
      failures++;
      $display("FAIL reset_regs got=%0d/%0d/%0d want=0/0/0", dut.current_state, dut.fill_counter, dut.read_counter);
    end
    checks++;
    if ({dut.LB1.wrPntr, dut.LB2.wrPntr, dut.LB3.wrPntr, dut.LB4.wrPntr, dut.LB5.wrPntr, dut.LB6.wrPntr} !== 66'd0) begin
      failures++;
      $display("FAIL reset_wrpntr got nonzero want=0");
    end
    checks++;
    if (o_ready !== 1'b0 || tile !== 384'd0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b want ready=0 and zero tile", o_ready);
    end
    i_rst = 1'b0;
  endtask
  task automatic test_init_fill;
    send(1536, 1'b1, 6'b000001);
    checks++;
    if (dut.LB1.wrPntr !== 11'd0) begin
      failures++;
      $display("FAIL lb1_wrap got=%0d want=0", dut.LB1.wrPntr);
    end
    send(1, 1'b1, 6'b000010);
    send(4607, 1'b0, 6'b0);
    checks++;
    if (dut.current_state !== 2'd1 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL init_done got state=%0d ready=%b want state=1 ready=0", dut.current_state, o_ready);
    end
    checks++;
    if ({dut.LB1.line[0], dut.LB1.line[1535], dut.LB4.line[3]} !== {8'd0, 8'd255, 8'd3}) begin
      failures++;
      $display("FAIL lb_contents got=%0d,%0d,%0d want=0,255,3", dut.LB1.line[0], dut.LB1.line[1535], dut.LB4.line[3]);
    end
    tick;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL first_ready got=%b want=1", o_ready);
    end
  endtask
  task automatic test_first_tile;
    checks++;
    if (row32(tile, 0, 0) !== {8'd0, 8'd3, 8'd6, 8'd9}) begin
      failures++;
      $display("FAIL tile0_c0r0 got=%h want=00030609", row32(tile, 0, 0));
    end
    checks++;
    if (row32(tile, 1, 0) !== {8'd1, 8'd4, 8'd7, 8'd10}) begin
      failures++;
      $display("FAIL tile0_c1r0 got=%h want=0104070a", row32(tile, 1, 0));
    end
    checks++;
    if (row32(tile, 2, 3) !== {8'd2, 8'd5, 8'd8, 8'd11}) begin
      failures++;
      $display("FAIL tile0_c2r3 got=%h want=0205080b", row32(tile, 2, 3));
    end
  endtask
  task automatic test_proc_finish;
    proc_finish = 1'b1;
    tick;
    checks++;
    if (o_ready !== 1'b0 || dut.read_counter !== 20'd1) begin
      failures++;
      $display("FAIL pf_drop got ready=%b rc=%0d want ready=0 rc=1", o_ready, dut.read_counter);
    end
    tick;
    proc_finish = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || dut.read_counter !== 20'd1) begin
      failures++;
      $display("FAIL pf_ignored got ready=%b rc=%0d want ready=1 rc=1", o_ready, dut.read_counter);
    end
    checks++;
    if (row32(tile, 0, 0) !== {8'd6, 8'd9, 8'd12, 8'd15}) begin
      failures++;
      $display("FAIL tile1_c0r0 got=%h want=06090c0f", row32(tile, 0, 0));
    end
  endtask
  task automatic test_fill_discard;
    send(3072, 1'b0, 6'b0);
    checks++;
    if (dut.current_state !== 2'd1 || dut.fill_counter !== 20'd3072) begin
      failures++;
      $display("FAIL fill_full got state=%0d fc=%0d want state=1 fc=3072", dut.current_state, dut.fill_counter);
    end
    checks++;
    if ({dut.LB5.line[5], dut.LB6.line[1535]} !== {8'd5, 8'd255}) begin
      failures++;
      $display("FAIL lb56_contents got=%0d,%0d want=5,255", dut.LB5.line[5], dut.LB6.line[1535]);
    end
    cnt += 100;
    send(10, 1'b1, 6'b000000);
    checks++;
    if ({dut.LB5.wrPntr, dut.LB6.wrPntr, dut.fill_counter} !== {11'd0, 11'd0, 20'd3072}) begin
      failures++;
      $display("FAIL discard_ptr got=%0d,%0d,%0d want=0,0,3072", dut.LB5.wrPntr, dut.LB6.wrPntr, dut.fill_counter);
    end
    checks++;
    if ({dut.LB5.line[0], dut.LB6.line[0]} !== 16'd0) begin
      failures++;
      $display("FAIL discard_data got=%0d,%0d want=0,0", dut.LB5.line[0], dut.LB6.line[0]);
    end
  endtask
  task automatic test_drain;
    for (int t = 1; t < 255; t++) begin
      wait_ready;
      if (t == 100) begin
        checks++;
        if (row32(tile, 2, 1) !== {8'd90, 8'd93, 8'd96, 8'd99}) begin
          failures++;
          $display("FAIL tile100_c2r1 got=%h want=5a5d6063", row32(tile, 2, 1));
        end
      end
      if (t == 254) begin
        checks++;
        if (dut.current_state !== 2'd1 || dut.read_counter !== 20'd254) begin
          failures++;
          $display("FAIL before_last got state=%0d rc=%0d want state=1 rc=254", dut.current_state, dut.read_counter);
        end
      end
      proc_finish = 1'b1;
      tick;
      proc_finish = 1'b0;
    end
    checks++;
    if (dut.current_state !== 2'd2 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL to_state2 got state=%0d ready=%b want state=2 ready=0", dut.current_state, o_ready);
    end
    tick;
    checks++;
    if (o_ready !== 1'b1 || dut.read_counter !== 20'd0 || dut.fill_counter !== 20'd0) begin
      failures++;
      $display("FAIL state2_start got ready=%b rc=%0d fc=%0d want 1/0/0", o_ready, dut.read_counter, dut.fill_counter);
    end
    checks++;
    if (row32(tile, 1, 2) !== {8'd1, 8'd4, 8'd7, 8'd10} || row32(tile, 0, 3) !== {8'd0, 8'd3, 8'd6, 8'd9}) begin
      failures++;
      $display("FAIL s2_tile0 got=%h,%h want=0104070a,00030609", row32(tile, 1, 2), row32(tile, 0, 3));
    end
  endtask
  task automatic test_mid_reset;
    send(100, 1'b1, 6'b000001);
    checks++;
    if (dut.LB1.wrPntr !== 11'd100 || dut.fill_counter !== 20'd100) begin
      failures++;
      $display("FAIL s2_fill got ptr=%0d fc=%0d want 100/100", dut.LB1.wrPntr, dut.fill_counter);
    end
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    checks++;
    if (dut.current_state !== 2'd0 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state got state=%0d ready=%b want 0/0", dut.current_state, o_ready);
    end
    checks++;
    if ({dut.fill_counter, dut.read_counter, dut.LB1.wrPntr} !== 51'd0) begin
      failures++;
      $display("FAIL mid_reset_cnt got fc=%0d rc=%0d ptr=%0d want 0/0/0", dut.fill_counter, dut.read_counter, dut.LB1.wrPntr);
    end
  endtask
  initial begin
    #1;
    test_reset;
    test_init_fill;
    test_first_tile;
    test_proc_finish;
    test_fill_discard;
    test_drain;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
